// File: rtl/decode_stage.sv
// RV32I decode stage: main/ALU decoders, immediate extender and the ID/EX
// pipeline register feeding the execute stage one cycle later.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  op_s;
  logic [2:0]  funct3_s;
  logic        funct7b5_s;
  logic [1:0]  imm_src_s;
  logic [1:0]  alu_op_s;

  logic        reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]  result_src_d;
  logic [2:0]  alu_control_d;
  logic [31:0] imm_ext_d;

  logic        reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
  logic [1:0]  result_src_q;
  logic [2:0]  alu_control_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q, rd1_q, rd2_q, imm_ext_q, pc_plus4_q;

  assign op_s       = InstrD[6:0];
  assign funct3_s   = InstrD[14:12];
  assign funct7b5_s = InstrD[30];

  // Main decoder: unknown opcodes decode to an all-zero NOP.
  always_comb begin
    reg_write_d  = 1'b0;
    imm_src_d_default();
    alu_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 2'b00;
    branch_d     = 1'b0;
    alu_op_s     = 2'b00;
    jump_d       = 1'b0;
    imm_src_s    = 2'b00;
    case (op_s)
      7'b0000011: begin
        reg_write_d = 1'b1; alu_src_d = 1'b1; result_src_d = 2'b01;
      end
      7'b0100011: begin
        imm_src_s = 2'b01; alu_src_d = 1'b1; mem_write_d = 1'b1;
      end
      7'b0110011: begin
        reg_write_d = 1'b1; alu_op_s = 2'b10;
      end
      7'b1100011: begin
        imm_src_s = 2'b10; branch_d = 1'b1; alu_op_s = 2'b01;
      end
      7'b0010011: begin
        reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_s = 2'b10;
      end
      7'b1101111: begin
        reg_write_d = 1'b1; imm_src_s = 2'b11; result_src_d = 2'b10; jump_d = 1'b1;
      end
      default: begin
        reg_write_d = 1'b0;
      end
    endcase
  end

  function automatic void imm_src_d_default();
  endfunction

  // ALU decoder; subtract on funct3 000 only for R-type with funct7[5] set.
  always_comb begin
    alu_control_d = 3'b000;
    case (alu_op_s)
      2'b00: alu_control_d = 3'b000;
      2'b01: alu_control_d = 3'b001;
      2'b10: begin
        case (funct3_s)
          3'b000: begin
            if (op_s[5] && funct7b5_s) alu_control_d = 3'b001;
            else                       alu_control_d = 3'b000;
          end
          3'b010:  alu_control_d = 3'b101;
          3'b110:  alu_control_d = 3'b011;
          3'b111:  alu_control_d = 3'b010;
          default: alu_control_d = 3'b000;
        endcase
      end
      default: alu_control_d = 3'b000;
    endcase
  end

  // Immediate extender, sign taken from InstrD[31].
  always_comb begin
    imm_ext_d = 32'h0000_0000;
    case (imm_src_s)
      2'b00:   imm_ext_d = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01:   imm_ext_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_ext_d = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11:   imm_ext_d = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext_d = 32'h0000_0000;
    endcase
  end

  // ID/EX register; reset inserts a bubble and overrides the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      jump_q        <= 1'b0;
      branch_q      <= 1'b0;
      alu_src_q     <= 1'b0;
      result_src_q  <= 2'b00;
      alu_control_q <= 3'b000;
      rd_q          <= 5'd0;
      pc_q          <= 32'h0000_0000;
      rd1_q         <= 32'h0000_0000;
      rd2_q         <= 32'h0000_0000;
      imm_ext_q     <= 32'h0000_0000;
      pc_plus4_q    <= 32'h0000_0000;
    end else begin
      reg_write_q   <= reg_write_d;
      mem_write_q   <= mem_write_d;
      jump_q        <= jump_d;
      branch_q      <= branch_d;
      alu_src_q     <= alu_src_d;
      result_src_q  <= result_src_d;
      alu_control_q <= alu_control_d;
      rd_q          <= InstrD[11:7];
      pc_q          <= PCD;
      rd1_q         <= RD1D;
      rd2_q         <= RD2D;
      imm_ext_q     <= imm_ext_d;
      pc_plus4_q    <= PCPlus4D;
    end
  end

  assign RegWriteE   = reg_write_q;
  assign MemWriteE   = mem_write_q;
  assign JumpE       = jump_q;
  assign BranchE     = branch_q;
  assign ALUSrcE     = alu_src_q;
  assign ResultSrcE  = result_src_q;
  assign ALUControlE = alu_control_q;
  assign RdE         = rd_q;
  assign PCE         = pc_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_ext_q;
  assign PCPlus4E    = pc_plus4_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage against an instruction-level
// reference model of RV32I decode.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RdE;
  logic [31:0] PCE, RD1E, RD2E, ImmExtE, PCPlus4E;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } exp_t;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RD1D(RD1D), .RD2D(RD2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RdE(RdE), .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural decode of one instruction by instruction class.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] pc4, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic rst);
    exp_t e;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic [2:0] arith;
    e = '0;
    if (rst) return e;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[14:12])
      3'b000:  arith = (ins[6:0] == 7'b0110011 && ins[30]) ? 3'b001 : 3'b000;
      3'b010:  arith = 3'b101;
      3'b110:  arith = 3'b011;
      3'b111:  arith = 3'b010;
      default: arith = 3'b000;
    endcase
    e.rd  = ins[11:7];
    e.pc  = pc;
    e.pc4 = pc4;
    e.rd1 = r1;
    e.rd2 = r2;
    e.imm = int'(i12);
    case (ins[6:0])
      7'b0000011: begin e.reg_write = 1'b1; e.alu_src = 1'b1; e.result_src = 2'b01; end
      7'b0100011: begin e.mem_write = 1'b1; e.alu_src = 1'b1; e.imm = int'(s12); end
      7'b0110011: begin e.reg_write = 1'b1; e.alu_control = arith; end
      7'b1100011: begin e.branch = 1'b1; e.alu_control = 3'b001; e.imm = int'(b13); end
      7'b0010011: begin e.reg_write = 1'b1; e.alu_src = 1'b1; e.alu_control = arith; end
      7'b1101111: begin
        e.reg_write = 1'b1; e.jump = 1'b1; e.result_src = 2'b10; e.imm = int'(j21);
      end
      default: e.reg_write = 1'b0;
    endcase
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".RegWriteE"},   32'(RegWriteE),   32'(e.reg_write));
    check({tag, ".MemWriteE"},   32'(MemWriteE),   32'(e.mem_write));
    check({tag, ".JumpE"},       32'(JumpE),       32'(e.jump));
    check({tag, ".BranchE"},     32'(BranchE),     32'(e.branch));
    check({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(e.alu_src));
    check({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(e.result_src));
    check({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(e.alu_control));
    check({tag, ".RdE"},         32'(RdE),         32'(e.rd));
    check({tag, ".PCE"},         PCE,              e.pc);
    check({tag, ".RD1E"},        RD1E,             e.rd1);
    check({tag, ".RD2E"},        RD2E,             e.rd2);
    check({tag, ".ImmExtE"},     ImmExtE,          e.imm);
    check({tag, ".PCPlus4E"},    PCPlus4E,         e.pc4);
  endtask

  // Apply one cycle of inputs, check after the edge, then toggle inputs and
  // confirm the E side holds.
  task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    reset    = rst;
    InstrD   = ins;
    PCD      = pc;
    PCPlus4D = pc + 32'd4;
    RD1D     = r1;
    RD2D     = r2;
    e = model(ins, pc, pc + 32'd4, r1, r2, rst);
    @(posedge clk);
    #1;
    check_all(tag, e);
    InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom; RD1D = $urandom; RD2D = $urandom;
    #2;
    check_all({tag, ".hold"}, e);
  endtask

  logic [6:0] ops [7];

  initial begin
    tests_run = 0;
    tests_failed = 0;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b1100011;
    ops[4] = 7'b0010011; ops[5] = 7'b1101111; ops[6] = 7'b1111111;
    reset = 1'b1; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h0; RD1D = 32'h0; RD2D = 32'h0;

    step("rst",   1'b1, 32'h0064A423, 32'h10, 32'h55, 32'h66);
    step("rst2",  1'b1, 32'h0064A423, 32'h14, 32'h77, 32'h88);
    step("rel",   1'b0, 32'h0064A423, 32'h18, 32'h99, 32'hAA);
    check("rel.MemWrite1", 32'(MemWriteE), 32'd1);
    step("lw",    1'b0, 32'hFFC4A303, 32'h1C, 32'h100, 32'h0);
    check("lw.imm_lit", ImmExtE, 32'hFFFFFFFC);
    step("sw",    1'b0, 32'h0064A423, 32'h20, 32'h200, 32'h5);
    check("sw.imm_lit", ImmExtE, 32'h00000008);
    step("sub",   1'b0, 32'h40628233, 32'h24, 32'h9, 32'h3);
    check("sub.alu_lit", 32'(ALUControlE), 32'd1);
    step("add",   1'b0, 32'h00628233, 32'h28, 32'h9, 32'h3);
    step("or",    1'b0, 32'h0062E233, 32'h2C, 32'h9, 32'h3);
    step("and",   1'b0, 32'h0062F233, 32'h30, 32'h9, 32'h3);
    step("slt",   1'b0, 32'h0062A233, 32'h34, 32'h9, 32'h3);
    step("addi_f7", 1'b0, 32'h40028213, 32'h38, 32'h1, 32'h2);
    step("beq",   1'b0, 32'h00420463, 32'h3C, 32'h4, 32'h4);
    check("beq.imm_lit", ImmExtE, 32'h00000008);
    step("jal",   1'b0, 32'h010000EF, 32'h20, 32'h0, 32'h0);
    check("jal.imm_lit", ImmExtE, 32'h00000010);
    check("jal.pc4_lit", PCPlus4E, 32'h00000024);
    step("unk",   1'b0, 32'h0000007F, 32'h40, 32'h1, 32'h2);
    step("midrst", 1'b1, 32'hFFC4A303, 32'h44, 32'h3, 32'h4);
    step("after", 1'b0, 32'hFFC4A303, 32'h48, 32'h3, 32'h4);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom);
      step($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0), ins,
           $urandom, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
